vector_issue_sequencer: RTL and testbench
=========================================

Name: vector_issue_sequencer

Overview:
- Sequences one vector instruction through the vector register file and the 4-PE datapath.
- On `start`, latches the configuration and walks VL in groups of 4 elements.
- Per group it issues register-file read addresses, then `write`/`elements_to_write`/`vd_addr` after a fixed PE latency.
- Sits between the decode/dispatch stage and vector_registers plus the PE array.

Parameters:
- PE_LATENCY, 2, cycles from group issue to its writeback (legal 1..4).
- MAX_VL, 32, largest legal VL (8 regs x 4 bytes, LMUL=8, 8b elements).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- vl  in  6  element count, 0..MAX_VL
- vsew_in  in  2  0=8b, 1=16b, 2=32b, 3 illegal
- widening_in  in  1  widening op (dest width = 2x source width)
- acc_in  in  1  op reads vd as third operand (MACC class)
- vs1_base, vs2_base, vd_base  in  5 each  base register numbers
- stall  in  1  PE back-pressure; freezes all sequencer state
- vs1_addr, vs2_addr, vd_addr  out  5 each  register-file addresses
- vsew, widening_op  out  2, 1  latched configuration to register file
- issue_valid  out  1  PE operands valid this cycle
- write  out  1  register-file write strobe
- elements_to_write  out  2  0=all 4, else count 1..3
- busy  out  1  instruction in flight
- done  out  1  one-cycle completion pulse
- cfg_error  out  1  one-cycle pulse with done on illegal config

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; group counter and writeback pipeline cleared. A reset mid-instruction aborts it: no done, no further writes.
- Groups:
  - G = ceil(vl/4).
  - Source step S = 1<<vsew.
  - Dest step D = 1<<eff_vsew, where eff_vsew = vsew+1 if widening, else vsew.
  - Group g addresses: vs1 = vs1_base + g*S, vs2 = vs2_base + g*S, vd = vd_base + g*D; all modulo 32, no overflow check.
- elements_to_write:
  - Last group: vl mod 4 (0 encodes a full group).
  - All other groups: 0.
- Config check in IDLE on start. Illegal if vsew=3 or (widening and vsew=2) → next cycle: done=1, cfg_error=1, busy=0, no issue, no write.
- vl=0 → next cycle done=1, cfg_error=0, no issue.
- States:
  - IDLE → RUN on legal start with vl>0; busy=1 from the next cycle.
  - RUN, acc_in=0: issue one group per unstalled cycle. issue_valid=1, vs1_addr/vs2_addr = group addresses. After the last issue → DRAIN.
  - RUN, acc_in=1: vd_addr is shared between vs3 read and write, so issue is non-overlapped. Issue group g with vd_addr = read address, then go to ACC_WAIT.
  - ACC_WAIT: hold until group g writes back, then → RUN (next group) or → DONE (last group).
  - DRAIN: wait until the writeback pipeline is empty → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Writeback pipeline: PE_LATENCY-deep shift register carrying {valid, vd address, elements_to_write}.
  - An entry retires exactly PE_LATENCY unstalled cycles after its issue; write=1 on that cycle.
  - When a write is retiring, vd_addr shows the write address. Otherwise vd_addr shows the current read address (acc) or the retiring/idle value (non-acc).
  - Non-acc ops: throughput 1 group/cycle. Issue of group g+PE_LATENCY coincides with writeback of g.
- stall=1: no state, counter, or pipeline change; issue_valid=0 and write=0 that cycle; addresses hold.
- start while busy: ignored.
- vsew/widening_op outputs: hold the latched values until the next accepted start.

Decomposition:
- Shared package vec_pkg: sew encoding constants (SEW8/16/32), state enum, MAX_VL, function computing eff_vsew.
- One natural sub-module: vec_wb_pipe, the parameterised PE_LATENCY-deep writeback shift register with stall.

Test Plan:
- vsew=0, vl=10, bases vs1=4, vs2=8, vd=12, PE_LATENCY=2, acc=0:
  - issues at cycles 1..3 with vs1=4,5,6.
  - writes at cycles 3..5 with vd=12,13,14 and elements_to_write=0,0,2.
  - done pulse on cycle 6.
- vsew=2, vl=8, vd=16:
  - two groups, vs addresses step by 4.
  - writes to vd=16 then 20, both elements_to_write=0.
- Widening with vsew=0, vl=8, acc=1, vd=8:
  - vd_addr = 8 for the read, write to 8 PE_LATENCY cycles later.
  - next issue only after that write; second group vd=10.
- Illegal configs: vsew=3, and widening with vsew=2 → done and cfg_error high for one cycle, no write. vl=0 → done without cfg_error.
- stall held 3 cycles mid-RUN: issue_valid=0 and write=0 while stalled; resumes with unchanged addresses; total writes still G.
- Reset asserted during DRAIN: all outputs 0 immediately; no done; start the following cycle runs normally.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared encodings, sequencer states and configuration helpers for the vector
// issue sequencer.
package vec_pkg;

    localparam logic [1:0] SEW8  = 2'd0;
    localparam logic [1:0] SEW16 = 2'd1;
    localparam logic [1:0] SEW32 = 2'd2;

    localparam int unsigned MAX_VL = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StAccWait,
        StDrain,
        StDone
    } state_e;

    // Destination element width; a widening op doubles the source width.
    function automatic logic [1:0] eff_vsew(input logic [1:0] vsew, input logic widening);
        return vsew + {1'b0, widening};
    endfunction

    // Register-number stride per 4-element group for a given element width.
    function automatic logic [4:0] sew_step(input logic [1:0] sew);
        logic [4:0] step;
        case (sew)
            SEW8:    step = 5'd1;
            SEW16:   step = 5'd2;
            SEW32:   step = 5'd4;
            default: step = 5'd8;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/vec_wb_pipe.sv
// Writeback pipeline: a LATENCY-deep shift register of {valid, vd, elements_to_write}
// that freezes entirely while stalled.
module vec_wb_pipe #(
    parameter int unsigned LATENCY = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stall,
    input  logic       i_push,
    input  logic [4:0] i_vd,
    input  logic [1:0] i_etw,
    output logic       o_valid,
    output logic [4:0] o_vd,
    output logic [1:0] o_etw,
    output logic       o_pending
);

    logic [LATENCY-1:0] r_valid;
    logic [4:0]         r_vd  [LATENCY];
    logic [1:0]         r_etw [LATENCY];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_vd[i]  <= 5'd0;
                r_etw[i] <= 2'd0;
            end
        end else if (!i_stall) begin
            r_valid[0] <= i_push;
            // Data only loads on a push so the tail keeps the last written address.
            if (i_push) begin
                r_vd[0]  <= i_vd;
                r_etw[0] <= i_etw;
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_valid[i] <= r_valid[i-1];
                r_vd[i]    <= r_vd[i-1];
                r_etw[i]   <= r_etw[i-1];
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_vd    = r_vd[LATENCY-1];
    assign o_etw   = r_etw[LATENCY-1];

    // Entries still in flight behind the one at the tail.
    always_comb begin
        o_pending = 1'b0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            o_pending = o_pending | r_valid[i];
        end
    end

endmodule

// File: rtl/vector_issue_sequencer.sv
// Vector issue sequencer: walks VL in 4-element groups, issuing register-file reads
// and retiring writebacks a fixed PE latency later.
module vector_issue_sequencer
    import vec_pkg::*;
#(
    parameter int unsigned PE_LATENCY = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [5:0] i_vl,
    input  logic [1:0] i_vsew_in,
    input  logic       i_widening_in,
    input  logic       i_acc_in,
    input  logic [4:0] i_vs1_base,
    input  logic [4:0] i_vs2_base,
    input  logic [4:0] i_vd_base,
    input  logic       i_stall,
    output logic [4:0] o_vs1_addr,
    output logic [4:0] o_vs2_addr,
    output logic [4:0] o_vd_addr,
    output logic [1:0] o_vsew,
    output logic       o_widening_op,
    output logic       o_issue_valid,
    output logic       o_write,
    output logic [1:0] o_elements_to_write,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_cfg_error
);

    state_e     r_state;
    state_e     w_state_next;

    logic [1:0] r_vsew;
    logic       r_widen;
    logic       r_acc;
    logic       r_err;
    logic [1:0] r_vl_lsb;
    logic [4:0] r_grp_rem;
    logic [4:0] r_vs1;
    logic [4:0] r_vs2;
    logic [4:0] r_vd;
    logic [4:0] r_step_s;
    logic [4:0] r_step_d;

    logic [6:0] w_vl_p3;
    logic [4:0] w_groups;
    logic       w_cfg_bad;
    logic       w_accept;
    logic       w_issue;
    logic       w_last;
    logic [1:0] w_etw;
    logic       w_wb_valid;
    logic       w_wb_fire;
    logic       w_wb_pending;
    logic [4:0] w_wb_vd;
    logic [1:0] w_wb_etw;

    assign w_vl_p3   = {1'b0, i_vl} + 7'd3;
    assign w_groups  = w_vl_p3[6:2];
    assign w_cfg_bad = (i_vsew_in == 2'd3) || (i_widening_in && (i_vsew_in == SEW32))
                       || (32'(i_vl) > MAX_VL);
    assign w_accept  = (r_state == StIdle) && i_start && !i_stall;
    assign w_issue   = (r_state == StRun) && !i_stall;
    assign w_last    = (r_grp_rem == 5'd1);
    assign w_etw     = w_last ? r_vl_lsb : 2'd0;
    assign w_wb_fire = w_wb_valid && !i_stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = (w_cfg_bad || (i_vl == 6'd0)) ? StDone : StRun;
                end
            end
            StRun: begin
                if (!i_stall) begin
                    if (r_acc) begin
                        w_state_next = StAccWait;
                    end else if (w_last) begin
                        w_state_next = StDrain;
                    end
                end
            end
            StAccWait: begin
                if (w_wb_fire) begin
                    w_state_next = (r_grp_rem == 5'd0) ? StDone : StRun;
                end
            end
            StDrain: begin
                if (!i_stall && !w_wb_pending) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (!i_stall) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vsew    <= 2'd0;
            r_widen   <= 1'b0;
            r_acc     <= 1'b0;
            r_err     <= 1'b0;
            r_vl_lsb  <= 2'd0;
            r_grp_rem <= 5'd0;
            r_vs1     <= 5'd0;
            r_vs2     <= 5'd0;
            r_vd      <= 5'd0;
            r_step_s  <= 5'd0;
            r_step_d  <= 5'd0;
        end else if (w_accept) begin
            r_vsew    <= i_vsew_in;
            r_widen   <= i_widening_in;
            r_acc     <= i_acc_in;
            r_err     <= w_cfg_bad;
            r_vl_lsb  <= i_vl[1:0];
            r_grp_rem <= w_groups;
            r_vs1     <= i_vs1_base;
            r_vs2     <= i_vs2_base;
            r_vd      <= i_vd_base;
            r_step_s  <= sew_step(i_vsew_in);
            r_step_d  <= sew_step(eff_vsew(i_vsew_in, i_widening_in));
        end else if (w_issue) begin
            // Addresses wrap modulo 32 through natural 5-bit overflow.
            r_vs1     <= r_vs1 + r_step_s;
            r_vs2     <= r_vs2 + r_step_s;
            r_vd      <= r_vd + r_step_d;
            r_grp_rem <= r_grp_rem - 5'd1;
        end
    end

    vec_wb_pipe #(
        .LATENCY (PE_LATENCY)
    ) u_wb_pipe (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_stall   (i_stall),
        .i_push    (w_issue),
        .i_vd      (r_vd),
        .i_etw     (w_etw),
        .o_valid   (w_wb_valid),
        .o_vd      (w_wb_vd),
        .o_etw     (w_wb_etw),
        .o_pending (w_wb_pending)
    );

    assign o_vs1_addr          = r_vs1;
    assign o_vs2_addr          = r_vs2;
    // Acc ops expose the vs3 read address whenever no writeback occupies the port.
    assign o_vd_addr           = (r_acc && !w_wb_valid) ? r_vd : w_wb_vd;
    assign o_vsew              = r_vsew;
    assign o_widening_op       = r_widen;
    assign o_issue_valid       = w_issue;
    assign o_write             = w_wb_fire;
    assign o_elements_to_write = w_wb_etw;
    assign o_busy              = (r_state == StRun) || (r_state == StAccWait)
                                 || (r_state == StDrain);
    assign o_done              = (r_state == StDone) && !i_stall;
    assign o_cfg_error         = (r_state == StDone) && !i_stall && r_err;

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Self-checking bench for vector_issue_sequencer: directed and randomized instructions
// checked cycle by cycle against a schedule computed from the group/latency rules.
module tb_vector_issue_sequencer;

    localparam int unsigned LAT = 2;
    localparam int MAXC = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] vl;
    logic [1:0] vsew_in;
    logic       widening_in;
    logic       acc_in;
    logic [4:0] vs1_base;
    logic [4:0] vs2_base;
    logic [4:0] vd_base;
    logic       stall;
    logic [4:0] vs1_addr;
    logic [4:0] vs2_addr;
    logic [4:0] vd_addr;
    logic [1:0] vsew;
    logic       widening_op;
    logic       issue_valid;
    logic       write;
    logic [1:0] etw;
    logic       busy;
    logic       done;
    logic       cfg_error;

    int vectors = 0;
    int miscompares = 0;
    bit pat [MAXC];

    always #5 clk = ~clk;

    vector_issue_sequencer #(
        .PE_LATENCY (LAT)
    ) dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_start             (start),
        .i_vl                (vl),
        .i_vsew_in           (vsew_in),
        .i_widening_in       (widening_in),
        .i_acc_in            (acc_in),
        .i_vs1_base          (vs1_base),
        .i_vs2_base          (vs2_base),
        .i_vd_base           (vd_base),
        .i_stall             (stall),
        .o_vs1_addr          (vs1_addr),
        .o_vs2_addr          (vs2_addr),
        .o_vd_addr           (vd_addr),
        .o_vsew              (vsew),
        .o_widening_op       (widening_op),
        .o_issue_valid       (issue_valid),
        .o_write             (write),
        .o_elements_to_write (etw),
        .o_busy              (busy),
        .o_done              (done),
        .o_cfg_error         (cfg_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit stalled(input int t);
        return (t >= 0 && t < MAXC) ? pat[t] : 1'b0;
    endfunction

    function automatic int next_free(input int t);
        int u = t;
        while (stalled(u)) u++;
        return u;
    endfunction

    // Cycle on which the n-th unstalled cycle strictly after t falls.
    function automatic int nth_after(input int t, input int n);
        int u = t;
        int c = 0;
        while (c < n) begin
            u++;
            if (!stalled(u)) c++;
        end
        return u;
    endfunction

    task automatic clear_pat();
        for (int i = 0; i < MAXC; i++) pat[i] = 1'b0;
    endtask

    task automatic check_all_zero();
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_write", write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_error", cfg_error, 0);
        chk("rst_vs1_addr", vs1_addr, 0);
        chk("rst_vs2_addr", vs2_addr, 0);
        chk("rst_vd_addr", vd_addr, 0);
        chk("rst_vsew", vsew, 0);
        chk("rst_widening_op", widening_op, 0);
        chk("rst_etw", etw, 0);
    endtask

    // Cycle 0 is the cycle start is driven high; reset_at > 0 aborts on that cycle.
    task automatic run_op(input int v, input int sew, input int wid, input int acc,
                          input int b1, input int b2, input int bd, input int reset_at);
        int  is_t[$];
        int  wr_t[$];
        int  done_t;
        int  last_t;
        int  last_wr;
        int  n_grp;
        int  s_step;
        int  d_step;
        int  writes_seen;
        bit  bad;
        bad    = (sew == 3) || (wid != 0 && sew == 2);
        n_grp  = (bad || v == 0) ? 0 : (v + 3) / 4;
        s_step = 1 << sew;
        d_step = 1 << (sew + wid);
        for (int g = 0; g < n_grp; g++) begin
            int e;
            if (g == 0) e = 1;
            else if (acc != 0) e = wr_t[g-1] + 1;
            else e = is_t[g-1] + 1;
            is_t.push_back(next_free(e));
            wr_t.push_back(nth_after(is_t[g], LAT));
        end
        last_wr = (n_grp == 0) ? 0 : wr_t[n_grp-1];
        done_t  = next_free(last_wr + 1);
        last_t  = (reset_at > 0) ? reset_at : done_t + 1;

        @(posedge clk);
        #1;
        vl          = 6'(v);
        vsew_in     = 2'(sew);
        widening_in = (wid != 0);
        acc_in      = (acc != 0);
        vs1_base    = 5'(b1);
        vs2_base    = 5'(b2);
        vd_base     = 5'(bd);
        stall       = 1'b0;
        start       = 1'b1;
        writes_seen = 0;

        for (int t = 1; t <= last_t; t++) begin
            int gi;
            int gw;
            @(posedge clk);
            #1;
            start = 1'b0;
            stall = stalled(t);
            #1;
            gi = -1;
            gw = -1;
            for (int g = 0; g < n_grp; g++) begin
                if (is_t[g] == t) gi = g;
                if (wr_t[g] == t) gw = g;
            end
            chk("issue_valid", issue_valid, 32'(gi >= 0));
            chk("write", write, 32'(gw >= 0));
            chk("done", done, 32'(t == done_t));
            chk("cfg_error", cfg_error, 32'(t == done_t && bad));
            chk("busy", busy, 32'(n_grp > 0 && t <= last_wr));
            if (write === 1'b1) writes_seen++;
            if (t == 1) begin
                chk("vsew", vsew, sew);
                chk("widening_op", widening_op, 32'(wid != 0));
            end
            if (gi >= 0) begin
                chk("vs1_addr", vs1_addr, (b1 + gi * s_step) & 31);
                chk("vs2_addr", vs2_addr, (b2 + gi * s_step) & 31);
                if (acc != 0) chk("vd_read_addr", vd_addr, (bd + gi * d_step) & 31);
            end
            if (gw >= 0) begin
                chk("vd_write_addr", vd_addr, (bd + gw * d_step) & 31);
                chk("elements_to_write", etw, (gw == n_grp - 1) ? (v % 4) : 0);
            end
            if (t == reset_at) begin
                reset = 1'b1;
                #1;
                check_all_zero();
            end
        end

        if (reset_at > 0) begin
            @(negedge clk);
            reset = 1'b0;
            stall = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #2;
                chk("post_rst_write", write, 0);
                chk("post_rst_done", done, 0);
                chk("post_rst_busy", busy, 0);
            end
        end else begin
            chk("write_count", writes_seen, n_grp);
        end
        stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        vl          = 6'd0;
        vsew_in     = 2'd0;
        widening_in = 1'b0;
        acc_in      = 1'b0;
        vs1_base    = 5'd0;
        vs2_base    = 5'd0;
        vd_base     = 5'd0;
        stall       = 1'b0;
        clear_pat();
        #1;
        check_all_zero();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed steps.
        run_op(10, 0, 0, 0, 4, 8, 12, 0);
        run_op(8, 2, 0, 0, 1, 3, 16, 0);
        run_op(8, 0, 1, 1, 2, 6, 8, 0);
        run_op(5, 3, 0, 0, 1, 2, 3, 0);
        run_op(8, 2, 1, 1, 1, 2, 3, 0);
        run_op(0, 0, 0, 0, 1, 2, 3, 0);
        run_op(4, 1, 1, 0, 30, 31, 28, 0);
        run_op(32, 0, 0, 1, 0, 16, 24, 0);
        pat[2] = 1'b1;
        pat[3] = 1'b1;
        pat[4] = 1'b1;
        run_op(16, 0, 0, 0, 4, 8, 12, 0);
        clear_pat();
        run_op(10, 0, 0, 0, 4, 8, 12, 4);
        run_op(10, 0, 0, 0, 4, 8, 12, 0);

        // Randomized instructions with random back-pressure.
        for (int n = 0; n < 40; n++) begin
            int rv;
            int rs;
            int rw;
            int ra;
            clear_pat();
            for (int t = 1; t < MAXC; t++) pat[t] = ($urandom_range(0, 7) == 0);
            rv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 32));
            rs = int'($urandom_range(0, 3));
            rw = int'($urandom_range(0, 1));
            ra = int'($urandom_range(0, 1));
            run_op(rv, rs, rw, ra, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), 0);
        end
        clear_pat();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
